// File: rtl/register_file.sv
//==============================================================================
// register_file : 16 x 16-bit register file, two async read ports, one write
//                 port, R0 hardwired to zero, write-to-read bypass.
// Revision      : 1.0
//==============================================================================
`default_nettype none

module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  SrcReg1,
  input  logic [3:0]  SrcReg2,
  input  logic [3:0]  DstReg,
  input  logic        WriteReg,
  input  logic [15:0] DstData,
  output logic [15:0] SrcData1,
  output logic [15:0] SrcData2
);

  localparam int          NUM_REGS = 16;
  localparam int          DATA_W   = 16;
  localparam logic [3:0]  ZERO_REG = 4'd0;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_active;

  // R0 is excluded here so it can never leave its reset value.
  assign wr_active = WriteReg && (DstReg != ZERO_REG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_active) begin
      regs[DstReg] <= DstData;
    end
  end

  // Reset forces zero and suppresses the bypass; the bypass takes priority
  // over stored contents so a reader sees the value about to be written.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] idx);
    logic [DATA_W-1:0] data;
    data = '0;
    if (!rst) begin
      data = '0;
    end else if (wr_active && (idx == DstReg)) begin
      data = DstData;
    end else if (idx == ZERO_REG) begin
      data = '0;
    end else begin
      data = regs[idx];
    end
    return data;
  endfunction

  always_comb begin
    SrcData1 = '0;
    SrcData2 = '0;
    SrcData1 = read_port(SrcReg1);
    SrcData2 = read_port(SrcReg2);
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
//==============================================================================
// tb_register_file : scoreboard-based self-checking bench for register_file.
// Revision         : 1.0
//==============================================================================
`default_nettype none

module tb_register_file;

  logic        clk;
  logic        rst;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] model [16];
  logic [15:0] exp_q [$];
  string       tag_q [$];

  register_file dut (
    .clk      (clk),
    .rst      (rst),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference storage follows the clock edge; async clear happens in drive().
  always @(posedge clk) begin
    if (rst && WriteReg && (DstReg != 4'd0)) begin
      model[DstReg] = DstData;
    end
  end

  task automatic check_value(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expected_read(input logic [3:0] idx);
    if (!rst)                                          return 16'h0000;
    if (WriteReg && DstReg != 4'd0 && idx == DstReg)   return DstData;
    if (idx == 4'd0)                                   return 16'h0000;
    return model[idx];
  endfunction

  // Drive one cycle of stimulus between edges, queue expectations, then
  // compare once the combinational read path has settled.
  task automatic drive(input logic r, input logic we, input logic [3:0] dst,
                       input logic [15:0] data, input logic [3:0] s1,
                       input logic [3:0] s2, input string tag);
    @(negedge clk);
    rst      = r;
    WriteReg = we;
    DstReg   = dst;
    DstData  = data;
    SrcReg1  = s1;
    SrcReg2  = s2;
    if (!r) begin
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    end
    exp_q.push_back(expected_read(s1));
    tag_q.push_back({tag, "/p1"});
    exp_q.push_back(expected_read(s2));
    tag_q.push_back({tag, "/p2"});
    #1;
    check_value(tag_q.pop_front(), SrcData1, exp_q.pop_front());
    check_value(tag_q.pop_front(), SrcData2, exp_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    rst = 1'b0; WriteReg = 1'b0; DstReg = '0; DstData = '0;
    SrcReg1 = '0; SrcReg2 = '0;

    // Reset: every index reads zero; writes and bypass are blocked
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'(i), 16'hA5A5, 4'(i), 4'(15 - i), "rst_read");
    end

    // Write R1 with bypass, then plain read-back
    drive(1'b1, 1'b1, 4'd1, 16'h0001, 4'd1, 4'd2, "bypass_r1");
    drive(1'b1, 1'b0, 4'd1, 16'h0000, 4'd1, 4'd2, "read_r1");

    // Write R2, then a disabled write must not disturb it
    drive(1'b1, 1'b1, 4'd2, 16'hFACE, 4'd3, 4'd4, "wr_r2");
    drive(1'b1, 1'b0, 4'd2, 16'h2222, 4'd2, 4'd2, "we0_r2");
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd2, 4'd2, "hold_r2");

    // R0 ignores writes and never bypasses
    drive(1'b1, 1'b1, 4'd0, 16'h2222, 4'd0, 4'd0, "r0_before");
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd1, "r0_after");

    // Back-to-back writes to R10: last one wins
    drive(1'b1, 1'b1, 4'd10, 16'h1111, 4'd10, 4'd5, "r10_w1");
    drive(1'b1, 1'b1, 4'd10, 16'hFACE, 4'd10, 4'd10, "r10_w2");
    drive(1'b1, 1'b0, 4'd10, 16'h0000, 4'd10, 4'd10, "r10_read");

    // Async reset mid-operation clears R15 immediately
    drive(1'b1, 1'b1, 4'd15, 16'hBEEF, 4'd15, 4'd15, "r15_wr");
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd15, 4'd10, "r15_read");
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd15, 4'd10, "r15_rst");
    drive(1'b0, 1'b1, 4'd15, 16'h7777, 4'd15, 4'd15, "rst_blk_wr");
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd15, 4'd2, "r15_post_rst");
    drive(1'b1, 1'b1, 4'd15, 16'h1234, 4'd15, 4'd14, "r15_rewr");
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd15, 4'd15, "r15_reread");

    // Randomised traffic with occasional reset pulses
    for (int n = 0; n < 60; n++) begin
      drive(($urandom_range(0, 19) != 0), 1'($urandom), 4'($urandom),
            16'($urandom), 4'($urandom), 4'($urandom), "rand");
    end

    // Final sweep of stored contents
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'(i), 4'(i), "sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001: Parameters: none; 16 entries, 16-bit data, fixed.
REQ-002: The design SHALL have one clock; reset is asynchronous and active-low.
REQ-003: clk  input  1  sole clock; all register updates on the rising edge.
REQ-004: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005: SrcReg1  input  4  read port 1 register index.
REQ-006: SrcReg2  input  4  read port 2 register index.
REQ-007: DstReg  input  4  write port register index.
REQ-008: WriteReg  input  1  write enable, active-high.
REQ-009: DstData  input  16  write data.
REQ-010: SrcData1  output  16  read port 1 data.
REQ-011: SrcData2  output  16  read port 2 data.

Function
REQ-012: Storage SHALL be 16 registers R0-R15, 16 bits each.
REQ-013: Write: on a rising clk edge with rst=1 and WriteReg=1, R[DstReg] SHALL load DstData; all other registers hold.
REQ-014: WriteReg=0 SHALL leave all registers unchanged regardless of DstReg/DstData.
REQ-015: Reads SHALL be combinational, zero-latency: SrcDataN = R[SrcRegN].
REQ-016: R0 SHALL read as 16'h0000 always; writes to R0 SHALL be ignored.
REQ-017: Write-before-read bypass: when WriteReg=1, DstReg!=0 and SrcRegN==DstReg, SrcDataN SHALL equal DstData in the same cycle (before the edge).
REQ-018: Bypass SHALL apply independently to both read ports; both ports reading DstReg SHALL both return DstData.
REQ-019: SrcReg1==SrcReg2 SHALL return identical data on both ports.
REQ-020: Outputs SHALL never be X/Z once reset has been applied.
REQ-021: Writing the same register on consecutive cycles SHALL keep only the last value; no write ordering beyond one write per edge.

Reset
REQ-022: rst=0 SHALL immediately (without a clock edge) clear R0-R15 to 16'h0000.
REQ-023: While rst=0, writes SHALL be blocked; registers remain 0.
REQ-024: Bypass SHALL be disabled while rst=0; SrcData1/SrcData2 SHALL read 16'h0000.
REQ-025: Reset asserted mid-operation SHALL discard all contents; the first write is accepted on the first rising edge after rst returns to 1.

Verification
REQ-026: Reset then read all 16 indices on both ports -> every read 16'h0000.
REQ-027: rst=1, WriteReg=1, DstReg=1, DstData=16'h0001, SrcReg1=1, SrcReg2=2 -> before edge SrcData1=0001 (bypass), SrcData2=0000; after edge, WriteReg=0 -> SrcData1=0001, SrcData2=0000.
REQ-028: Write R2=16'hFACE, then WriteReg=0, DstReg=2, DstData=16'h2222 -> R2 reads FACE on both ports after edge.
REQ-029: WriteReg=1, DstReg=0, DstData=16'h2222, SrcReg1=0 -> SrcData1=0000 before and after edge.
REQ-030: Write R10=16'h1111 then R10=16'hFACE on consecutive edges -> SrcData reads 1111 after first edge, FACE after second.
REQ-031: Write R15=16'hBEEF, assert rst=0 between edges -> SrcData for R15 drops to 0000 immediately, stays 0000 after rst release until a new write.
